// File: rtl/countdown_timer_core_if.sv
// Control/status bundle for countdown_timer_core: count-enable, start/stop/preset
// strobes in, BCD digits and status flags out.
interface countdown_timer_core_if #(
  parameter int unsigned FIELDS = 2,
  parameter int unsigned LED_W  = 16
);
  logic                  tick_1hz;
  logic                  start_pause;
  logic                  stop;
  logic                  inc_sec;
  logic                  inc_min;
  logic                  inc_hr;
  logic [8*FIELDS-1:0]   digits;
  logic                  running;
  logic                  done;
  logic [LED_W-1:0]      led;

  modport master (
    output tick_1hz, start_pause, stop, inc_sec, inc_min, inc_hr,
    input  digits, running, done, led
  );

  modport slave (
    input  tick_1hz, start_pause, stop, inc_sec, inc_min, inc_hr,
    output digits, running, done, led
  );
endinterface

// File: rtl/countdown_timer_core.sv
// BCD countdown timer (MM:SS or HH:MM:SS) with SET/RUN/PAUSE/DONE control.
// Optional macro TIMER_AUTORELOAD_EN: reload from preset on zero and keep running.
module countdown_timer_core #(
  parameter int unsigned FIELDS = 2,
  parameter int unsigned LED_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  countdown_timer_core_if.slave  bus
);

  localparam int unsigned DW = 8 * FIELDS;

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     preset_q, preset_d;
  logic [DW-1:0]     count_q, count_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [DW-1:0]     dec_c;
`ifdef TIMER_AUTORELOAD_EN
  logic              reload_c;
`endif

  // Two-digit BCD increment, wrapping max -> 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] b, input logic [7:0] maxv);
    if (b == maxv)        return 8'h00;
    else if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
    else                  return {b[7:4], b[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement, 00 -> maxv.
  function automatic logic [7:0] bcd_dec(input logic [7:0] b, input logic [7:0] maxv);
    if (b == 8'h00)          return maxv;
    else if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
    else                     return {b[7:4], b[3:0] - 4'd1};
  endfunction

  // Preset edits wrap per field with no carry into the neighbour.
  function automatic logic [DW-1:0] preset_inc(input logic [DW-1:0] p, input logic is,
                                               input logic im, input logic ih);
    logic [DW-1:0] r;
    r = p;
    if (is) r[7:0]  = bcd_inc(p[7:0], 8'h59);
    if (im) r[15:8] = bcd_inc(p[15:8], 8'h59);
    if (FIELDS == 3 && ih) r[DW-1 -: 8] = bcd_inc(p[DW-1 -: 8], 8'h23);
    return r;
  endfunction

  // Whole-count decrement with borrow rippling up from seconds.
  function automatic logic [DW-1:0] count_dec(input logic [DW-1:0] c);
    logic [DW-1:0] r;
    logic          borrow;
    r      = c;
    borrow = 1'b1;
    for (int f = 0; f < int'(FIELDS); f++) begin
      if (borrow) begin
        borrow       = (c[8*f +: 8] == 8'h00);
        r[8*f +: 8]  = bcd_dec(c[8*f +: 8], (f == 2) ? 8'h23 : 8'h59);
      end
    end
    return r;
  endfunction

  assign dec_c = count_dec(count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SET;
      preset_q  <= '0;
      count_q   <= '0;
      digits_q  <= '0;
      led_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      digits_q  <= digits_d;
      led_q     <= led_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next state: stop outranks start_pause, which outranks tick.
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    count_d  = count_q;
`ifdef TIMER_AUTORELOAD_EN
    reload_c = 1'b0;
`endif
    unique case (state_q)
      ST_SET: begin
        if (bus.start_pause) begin
          count_d = preset_q;
          state_d = (preset_q == '0) ? ST_DONE : ST_RUN;
        end else begin
          preset_d = preset_inc(preset_q, bus.inc_sec, bus.inc_min, bus.inc_hr);
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_SET;
        end else if (bus.start_pause) begin
          state_d = ST_PAUSE;
        end else if (bus.tick_1hz) begin
          if (dec_c == '0) begin
`ifdef TIMER_AUTORELOAD_EN
            count_d  = preset_q;
            reload_c = 1'b1;
`else
            count_d  = '0;
            state_d  = ST_DONE;
`endif
          end else begin
            count_d = dec_c;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop)             state_d = ST_SET;
        else if (bus.start_pause) state_d = ST_RUN;
      end
      ST_DONE: begin
        count_d = '0;
        if (bus.stop) state_d = ST_SET;
      end
    endcase

    // Registered outputs follow the next state so they land on the same edge.
    led_d = '0;
    if (state_d == ST_DONE) begin
      if (state_q != ST_DONE) led_d = {LED_W{1'b1}};
      else if (bus.tick_1hz)  led_d = ~led_q;
      else                    led_d = led_q;
    end
    digits_d  = (state_d == ST_SET) ? preset_d : count_d;
    running_d = (state_d == ST_RUN);
`ifdef TIMER_AUTORELOAD_EN
    done_d    = (state_d == ST_DONE) || reload_c;
`else
    done_d    = (state_d == ST_DONE);
`endif
  end

  assign bus.digits  = digits_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.led     = led_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed self-checking bench: MM:SS and HH:MM:SS instances driven in lockstep.
module tb_countdown_timer_core;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  countdown_timer_core_if #(.FIELDS(2), .LED_W(16)) b2 ();
  countdown_timer_core_if #(.FIELDS(3), .LED_W(16)) b3 ();

  countdown_timer_core #(.FIELDS(2), .LED_W(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  countdown_timer_core #(.FIELDS(3), .LED_W(16)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic tk, input logic sp, input logic st,
                        input logic is, input logic im, input logic ih);
    b2.tick_1hz = tk; b2.start_pause = sp; b2.stop = st;
    b2.inc_sec  = is; b2.inc_min     = im; b2.inc_hr = ih;
    b3.tick_1hz = tk; b3.start_pause = sp; b3.stop = st;
    b3.inc_sec  = is; b3.inc_min     = im; b3.inc_hr = ih;
  endtask

  // Apply inputs for exactly one clock, sample 1 time unit after the edge.
  task automatic drv(input logic tk, input logic sp, input logic st,
                     input logic is, input logic im, input logic ih);
    set_in(tk, sp, st, is, im, ih);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic start_pause(); drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic stop();        drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle();        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic inc_s(input int n); for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic inc_m(input int n); for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic inc_h(input int n); for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    check("rst_digits",  32'(b2.digits),  32'h0000);
    check("rst_running", 32'(b2.running), 32'h0);
    check("rst_done",    32'(b2.done),    32'h0);
    check("rst_led",     32'(b2.led),     32'h0000);

    // 00:03 countdown to DONE, led toggling, stop keeps preset
    inc_s(3);
    check("p3_preset", 32'(b2.digits), 32'h0003);
    start_pause();
    check("p3_running", 32'(b2.running), 32'h1);
    tick(); check("p3_t1", 32'(b2.digits), 32'h0002);
    tick(); check("p3_t2", 32'(b2.digits), 32'h0001);
    tick();
`ifdef TIMER_AUTORELOAD_EN
    check("p3_t3_reload", 32'(b2.digits),  32'h0003);
    check("p3_t3_done",   32'(b2.done),    32'h1);
    check("p3_t3_run",    32'(b2.running), 32'h1);
    check("p3_t3_led",    32'(b2.led),     32'h0000);
    tick();
    check("p3_t4_digits", 32'(b2.digits), 32'h0002);
    check("p3_t4_done",   32'(b2.done),   32'h0);
`else
    check("p3_t3_digits", 32'(b2.digits),  32'h0000);
    check("p3_t3_done",   32'(b2.done),    32'h1);
    check("p3_t3_run",    32'(b2.running), 32'h0);
    check("p3_t3_led",    32'(b2.led),     32'hFFFF);
    tick(); check("p3_t4_led", 32'(b2.led), 32'h0000);
    start_pause(); check("p3_done_sp_ignored", 32'(b2.done), 32'h1);
    tick(); check("p3_t5_led", 32'(b2.led), 32'hFFFF);
`endif
    stop();
    check("p3_stop_digits", 32'(b2.digits), 32'h0003);
    check("p3_stop_done",   32'(b2.done),   32'h0);
    check("p3_stop_led",    32'(b2.led),    32'h0000);

    // 01:00 minute borrow
    do_reset();
    inc_m(1);
    start_pause();
    tick(); check("m1_t1", 32'(b2.digits), 32'h0059);
    tick(); check("m1_t2", 32'(b2.digits), 32'h0058);

    // Pause freezes count; inc ignored outside SET
    do_reset();
    inc_s(10);
    check("pz_preset", 32'(b2.digits), 32'h0010);
    start_pause();
    tick(); tick();
    check("pz_run2", 32'(b2.digits), 32'h0008);
    start_pause();
    check("pz_paused_run", 32'(b2.running), 32'h0);
    repeat (5) tick();
    check("pz_frozen", 32'(b2.digits), 32'h0008);
    inc_s(1);
    check("pz_inc_ignored", 32'(b2.digits), 32'h0008);
    start_pause();
    check("pz_resume_run", 32'(b2.running), 32'h1);
    tick(); check("pz_resume_t", 32'(b2.digits), 32'h0007);
    stop(); check("pz_stop_preset", 32'(b2.digits), 32'h0010);

    // Preset wrap without carry; hours on the 3-field instance
    do_reset();
    inc_m(1);
    inc_s(60);
    check("wr_sec60",   32'(b2.digits), 32'h0100);
    inc_s(10);
    check("wr_sec10",   32'(b2.digits), 32'h0110);
    inc_m(59);
    check("wr_min_wrap", 32'(b2.digits), 32'h0010);
    inc_h(24);
    check("wr_hr24",     32'(b3.digits), 32'h000010);
    check("wr_hr_ign2",  32'(b2.digits), 32'h0010);
    inc_h(23);
    check("wr_hr23",     32'(b3.digits), 32'h230010);

    // Hour borrow; zero preset goes straight to DONE
    do_reset();
    inc_h(1);
    start_pause();
    check("hb_start3",   32'(b3.digits), 32'h010000);
    check("zp_done",     32'(b2.done),   32'h1);
    check("zp_led",      32'(b2.led),    32'hFFFF);
    check("zp_running",  32'(b2.running), 32'h0);
    tick();
    check("hb_t1",       32'(b3.digits), 32'h005959);
    check("zp_led_tgl",  32'(b2.led),    32'h0000);

    // Priority: tick dropped under start_pause; stop beats start_pause
    do_reset();
    inc_s(5);
    start_pause();
    tick(); check("pr_t1", 32'(b2.digits), 32'h0004);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pr_tick_drop", 32'(b2.digits),  32'h0004);
    check("pr_paused",    32'(b2.running), 32'h0);
    start_pause();
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pr_stop_run",    32'(b2.running), 32'h0);
    check("pr_stop_digits", 32'(b2.digits),  32'h0005);
    check("pr_stop_done",   32'(b2.done),    32'h0);

    // Asynchronous reset mid-RUN
    start_pause();
    tick();
    check("ar_pre", 32'(b2.digits), 32'h0004);
    #2 rst_n = 1'b0;
    #1;
    check("ar_digits",  32'(b2.digits),  32'h0000);
    check("ar_running", 32'(b2.running), 32'h0);
    check("ar_done",    32'(b2.done),    32'h0);
    check("ar_led",     32'(b2.led),     32'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("ar_post_digits",  32'(b2.digits),  32'h0000);
    check("ar_post_running", 32'(b2.running), 32'h0);

    // 00:02 reaching zero: DONE, or reload when auto-reload is built in
    do_reset();
    inc_s(2);
    start_pause();
    tick(); check("az_t1", 32'(b2.digits), 32'h0001);
    tick();
`ifdef TIMER_AUTORELOAD_EN
    check("az_done",    32'(b2.done),    32'h1);
    check("az_digits",  32'(b2.digits),  32'h0002);
    check("az_running", 32'(b2.running), 32'h1);
    idle();
    check("az_done_pulse", 32'(b2.done), 32'h0);
`else
    check("az_done",    32'(b2.done),    32'h1);
    check("az_digits",  32'(b2.digits),  32'h0000);
    check("az_running", 32'(b2.running), 32'h0);
    idle();
    check("az_done_hold", 32'(b2.done), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
